// File: rtl/pll_phase_pkg.sv
// pll_phase_pkg: counter-select codes and FSM state encoding shared by the phase stepper
package pll_phase_pkg;
  localparam logic [2:0] CNT_ALL = 3'b000;
  localparam logic [2:0] CNT_M   = 3'b001;
  localparam logic [2:0] CNT_C0  = 3'b010;
  localparam logic [2:0] CNT_C1  = 3'b011;
  localparam logic [2:0] CNT_C2  = 3'b100;
  localparam logic [2:0] CNT_C3  = 3'b101;
  localparam logic [2:0] CNT_C4  = 3'b110;
  typedef enum logic [2:0] {IDLE, SETUP, STEP, WAITLOW, WAITHIGH, FINISH} state_t;
endpackage

// File: rtl/pll_scanclk_gen.sv
// pll_scanclk_gen: scanclk divider with enable and one-clk rise/fall strobes
//   clk, rst_n : system clock, async active-low reset
//   en         : run divider; when low scanclk is held low and the divider cleared
//   scanclk    : divided clock, SCAN_DIV clk cycles per half-period
//   rise/fall  : high in the clk cycle whose closing edge takes scanclk 0->1 / 1->0
module pll_scanclk_gen #(
  parameter int SCAN_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic scanclk,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic scanclk_q, scanclk_d, wrap;
  always_comb begin
    wrap      = en && (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d     = (!en || wrap) ? '0 : cnt_q + CW'(1);
    scanclk_d = en ? scanclk_q ^ wrap : 1'b0;
    rise      = wrap && !scanclk_q;
    fall      = wrap && scanclk_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      scanclk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      scanclk_q <= scanclk_d;
    end
  end
  assign scanclk = scanclk_q;
endmodule

// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: executes "step counter X by N up/down" on the PLL dynamic phase-shift port
//   cmd_valid/cmd_ready/cmd_steps/cmd_updown/cmd_cntsel : command handshake from the sweep logic
//   phase_done                                            : PLL phasedone, asynchronous, synchronised here
//   scanclk/phasestep/phaseupdown/phasecounterselect      : PLL phase-shift port
//   busy/done/err_timeout/steps_left                      : status
//   Optional macro PLL_PHASE_TRACK_EN adds phase_pos (signed 16-bit net position of counter-select "all")
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int SCAN_DIV      = 16,
  parameter int PHASESTEP_CYC = 2,
  parameter int TIMEOUT_CYC   = 100,
  parameter int STEP_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_updown,
  input  logic [2:0]        cmd_cntsel,
  input  logic              phase_done,
  output logic              scanclk,
  output logic              phasestep,
  output logic              phaseupdown,
  output logic [2:0]        phasecounterselect,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [STEP_W-1:0] steps_left
`ifdef PLL_PHASE_TRACK_EN
  ,output logic signed [15:0] phase_pos
`endif
);
  localparam logic [15:0] PS_N    = 16'(PHASESTEP_CYC);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  state_t state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [2:0] cntsel_q, cntsel_d;
  logic [15:0] cnt_q, cnt_d;
  logic updown_q, updown_d, ps_q, ps_d, abort_q, abort_d, done_q, done_d, err_q, err_d;
  logic pd_meta_q, pd_sync_q, rise, fall, seen;
`ifdef PLL_PHASE_TRACK_EN
  logic signed [15:0] pos_q, pos_d;
  assign phase_pos = pos_q;
`endif
  pll_scanclk_gen #(.SCAN_DIV(SCAN_DIV)) u_scanclk (
    .clk(clk), .rst_n(rst_n), .en(busy), .scanclk(scanclk), .rise(rise), .fall(fall)
  );
  assign busy               = state_q != IDLE;
  // ready is also withheld during the done cycle so a held cmd_valid is taken one clk after done
  assign cmd_ready          = !busy && !done_q;
  assign phasestep          = ps_q;
  assign phaseupdown        = updown_q;
  assign phasecounterselect = cntsel_q;
  assign done               = done_q;
  assign err_timeout        = err_q;
  assign steps_left         = steps_q;
  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    cntsel_d = cntsel_q;
    updown_d = updown_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    seen     = (state_q == WAITLOW) ? !pd_sync_q : pd_sync_q;
`ifdef PLL_PHASE_TRACK_EN
    pos_d    = pos_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        steps_d  = cmd_steps;
        updown_d = cmd_updown;
        cntsel_d = cmd_cntsel;
        abort_d  = 1'b0;
        cnt_d    = '0;
        if (cmd_steps == '0) done_d = 1'b1;
        else state_d = SETUP;
      end
      // cnt_q marks that a full scanclk rise has passed before phasestep is raised
      SETUP: if (rise) cnt_d = 16'd1;
        else if (fall && cnt_q != '0) begin
          ps_d    = 1'b1;
          cnt_d   = '0;
          state_d = STEP;
        end
      STEP: if (rise && cnt_q < PS_N) cnt_d = cnt_q + 16'd1;
        else if (fall && cnt_q >= PS_N) begin
          ps_d    = 1'b0;
          cnt_d   = '0;
          state_d = WAITLOW;
        end
      // cnt_q is the shared timeout over both wait states; a seen level wins over expiry
      WAITLOW, WAITHIGH: if (rise) begin
        cnt_d = cnt_q + 16'd1;
        if (seen && state_q == WAITLOW) state_d = WAITHIGH;
        else if (seen) begin
          steps_d = (steps_q != '0) ? steps_q - STEP_W'(1) : steps_q;
          state_d = (steps_q <= STEP_W'(1)) ? FINISH : SETUP;
          cnt_d   = '0;
`ifdef PLL_PHASE_TRACK_EN
          if (cntsel_q == CNT_ALL)
            pos_d = updown_q ? ((pos_q == 16'sh7fff) ? pos_q : pos_q + 16'sd1)
                             : ((pos_q == 16'sh8000) ? pos_q : pos_q - 16'sd1);
`endif
        end else if (cnt_q == TO_LAST) begin
          abort_d = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: if (fall) begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = abort_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      steps_q   <= '0;
      cntsel_q  <= CNT_ALL;
      updown_q  <= 1'b1;
      cnt_q     <= '0;
      ps_q      <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pd_meta_q <= 1'b0;
      pd_sync_q <= 1'b0;
`ifdef PLL_PHASE_TRACK_EN
      pos_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      cntsel_q  <= cntsel_d;
      updown_q  <= updown_d;
      cnt_q     <= cnt_d;
      ps_q      <= ps_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      err_q     <= err_d;
      pd_meta_q <= phase_done;
      pd_sync_q <= pd_meta_q;
`ifdef PLL_PHASE_TRACK_EN
      pos_q     <= pos_d;
`endif
    end
  end
endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb_pll_phase_stepper: directed scenarios against a behavioural PLL phasedone model
module tb_pll_phase_stepper;
  localparam int SCAN_DIV = 16, PHASESTEP_CYC = 2, TIMEOUT_CYC = 100, STEP_W = 8;
  localparam logic [16:0] RST_EXP = {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_updown = 0, phase_done = 1;
  logic [7:0] cmd_steps = 0;
  logic [2:0] cmd_cntsel = 0;
  logic cmd_ready, scanclk, phasestep, phaseupdown, busy, done, err_timeout;
  logic [2:0] phasecounterselect;
  logic [7:0] steps_left;
  logic [16:0] out_vec;
`ifdef PLL_PHASE_TRACK_EN
  logic signed [15:0] phase_pos;
`endif
  pll_phase_stepper #(.SCAN_DIV(SCAN_DIV), .PHASESTEP_CYC(PHASESTEP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_updown(cmd_updown), .cmd_cntsel(cmd_cntsel),
    .phase_done(phase_done), .scanclk(scanclk), .phasestep(phasestep),
    .phaseupdown(phaseupdown), .phasecounterselect(phasecounterselect), .busy(busy),
    .done(done), .err_timeout(err_timeout), .steps_left(steps_left)
`ifdef PLL_PHASE_TRACK_EN
    , .phase_pos(phase_pos)
`endif
  );
  assign out_vec = {scanclk, phasestep, phaseupdown, phasecounterselect, busy, done,
                    err_timeout, steps_left, cmd_ready};
  always #10 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit pll_stuck = 0;
  always @(negedge phasestep) if (!pll_stuck && rst_n) begin
    repeat (2 * SCAN_DIV) @(posedge clk);
    #3 phase_done = 0;
    repeat (4 * SCAN_DIV) @(posedge clk);
    #3 phase_done = 1;
  end
  int sc_toggles = 0, pulses = 0, done_cnt = 0, err_cnt = 0, ready_bad = 0, ps_viol = 0;
  int cur_w = 0, ps_fall_cyc = 0;
  int widths[$], sl_q[$];
  logic prev_sc = 0, prev_ps = 0;
  logic [7:0] prev_sl = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (scanclk != prev_sc) sc_toggles++;
      if (scanclk && !prev_sc && phasestep) cur_w++;
      if (phasestep != prev_ps && !(prev_sc && !scanclk)) ps_viol++;
      if (prev_ps && !phasestep) begin
        pulses++;
        widths.push_back(cur_w);
        cur_w = 0;
        ps_fall_cyc = cyc;
      end
      if (done) done_cnt++;
      if (err_timeout) err_cnt++;
      if (busy && cmd_ready) ready_bad++;
    end
    if (steps_left != prev_sl) sl_q.push_back(int'(steps_left));
    prev_sc = scanclk;
    prev_ps = phasestep;
    prev_sl = steps_left;
  end
  task automatic send(input int steps, input bit ud, input logic [2:0] sel);
    @(negedge clk);
    cmd_steps = 8'(steps); cmd_updown = ud; cmd_cntsel = sel; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wait_done(output bit got);
    got = 0;
    for (int i = 0; i < 8000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_vec !== RST_EXP) begin n_bad++; $display("FAIL reset_held got=%h exp=%h", out_vec, RST_EXP); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_vec !== RST_EXP) begin n_bad++; $display("FAIL reset_released got=%h exp=%h", out_vec, RST_EXP); end
  endtask
  task automatic test_three_steps;
    int d0 = done_cnt, e0 = err_cnt, p0 = pulses, w0 = widths.size(), h0 = sl_q.size(), v0 = ps_viol;
    int bad_w = 0;
    int exp_h[4] = '{3, 2, 1, 0};
    bit got;
    send(3, 1, 3'b010);
    n_cmp++; if (steps_left !== 8'd3) begin n_bad++; $display("FAIL s3_load steps_left got=%0d exp=3", steps_left); end
    n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL s3_busy_ready got=%b exp=10", {busy, cmd_ready}); end
    n_cmp++; if ({phaseupdown, phasecounterselect} !== 4'b1010) begin n_bad++; $display("FAIL s3_fields got=%b exp=1010", {phaseupdown, phasecounterselect}); end
    wait_done(got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL s3_done_seen got=%b exp=1", got); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL s3_err_at_done got=%b exp=0", err_timeout); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL s3_done_count got=%0d exp=1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL s3_err_count got=%0d exp=0", err_cnt - e0); end
    n_cmp++; if (pulses - p0 !== 3) begin n_bad++; $display("FAIL s3_pulses got=%0d exp=3", pulses - p0); end
    for (int i = w0; i < widths.size(); i++) if (widths[i] < PHASESTEP_CYC) bad_w++;
    n_cmp++; if (bad_w !== 0) begin n_bad++; $display("FAIL s3_pulse_width narrow_pulses got=%0d exp=0", bad_w); end
    n_cmp++; if (sl_q.size() - h0 !== 4) begin n_bad++; $display("FAIL s3_hist_len got=%0d exp=4", sl_q.size() - h0); end
    for (int i = 0; i < 4 && h0 + i < sl_q.size(); i++) begin
      n_cmp++; if (sl_q[h0 + i] !== exp_h[i]) begin n_bad++; $display("FAIL s3_hist[%0d] got=%0d exp=%0d", i, sl_q[h0 + i], exp_h[i]); end
    end
    n_cmp++; if (ps_viol - v0 !== 0) begin n_bad++; $display("FAIL s3_phasestep_timing off_fall_changes got=%0d exp=0", ps_viol - v0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL s3_idle busy got=%b exp=0", busy); end
  endtask
  task automatic test_zero_steps;
    int t0 = sc_toggles, p0 = pulses, busy_n = 0;
    @(negedge clk);
    cmd_steps = 0; cmd_updown = 0; cmd_cntsel = 3'b011; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    n_cmp++; if ({done, busy, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL z_done_pulse done_busy_ready got=%b exp=100", {done, busy, cmd_ready}); end
    @(negedge clk);
    n_cmp++; if ({done, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL z_after done_ready got=%b exp=01", {done, cmd_ready}); end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    n_cmp++; if (busy_n !== 0) begin n_bad++; $display("FAIL z_busy cycles got=%0d exp=0", busy_n); end
    n_cmp++; if (sc_toggles - t0 !== 0) begin n_bad++; $display("FAIL z_scanclk toggles got=%0d exp=0", sc_toggles - t0); end
    n_cmp++; if (pulses - p0 !== 0) begin n_bad++; $display("FAIL z_phasestep pulses got=%0d exp=0", pulses - p0); end
    n_cmp++; if (steps_left !== 8'd0) begin n_bad++; $display("FAIL z_steps_left got=%0d exp=0", steps_left); end
  endtask
  task automatic test_timeout;
    int p0 = pulses;
    bit got;
    pll_stuck = 1;
    send(5, 0, 3'b001);
    wait_done(got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL to_done_seen got=%b exp=1", got); end
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_err_with_done got=%b exp=1", err_timeout); end
    n_cmp++; if (cyc - ps_fall_cyc !== 2 * SCAN_DIV * TIMEOUT_CYC) begin n_bad++; $display("FAIL to_latency clks got=%0d exp=%0d", cyc - ps_fall_cyc, 2 * SCAN_DIV * TIMEOUT_CYC); end
    n_cmp++; if (steps_left !== 8'd5) begin n_bad++; $display("FAIL to_steps_left got=%0d exp=5", steps_left); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL to_pulses got=%0d exp=1", pulses - p0); end
    @(negedge clk);
    n_cmp++; if ({done, err_timeout, busy} !== 3'b000) begin n_bad++; $display("FAIL to_after got=%b exp=000", {done, err_timeout, busy}); end
    pll_stuck = 0;
  endtask
  task automatic test_reset_mid;
    int d0;
    bit found = 0, got;
    send(5, 1, 3'b001);
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (!phase_done) found = 1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rm_reach_wait got=%b exp=1", found); end
    repeat (30) @(negedge clk);
    d0 = done_cnt;
    #3 rst_n = 0;
    #1;
    n_cmp++; if (out_vec !== RST_EXP) begin n_bad++; $display("FAIL rm_immediate got=%h exp=%h", out_vec, RST_EXP); end
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    n_cmp++; if (out_vec !== RST_EXP) begin n_bad++; $display("FAIL rm_after_release got=%h exp=%h", out_vec, RST_EXP); end
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL rm_no_done got=%0d exp=%0d", done_cnt, d0); end
    send(1, 0, 3'b100);
    n_cmp++; if ({phaseupdown, phasecounterselect, steps_left} !== {1'b0, 3'b100, 8'd1}) begin n_bad++; $display("FAIL rm_next_load got=%h exp=%h", {phaseupdown, phasecounterselect, steps_left}, {1'b0, 3'b100, 8'd1}); end
    wait_done(got);
    n_cmp++; if ({got, err_timeout, steps_left} !== {1'b1, 1'b0, 8'd0}) begin n_bad++; $display("FAIL rm_next_done got=%h exp=%h", {got, err_timeout, steps_left}, {1'b1, 1'b0, 8'd0}); end
  endtask
  task automatic test_back_to_back;
    int early = 0;
    bit got = 0;
    @(negedge clk);
    cmd_steps = 1; cmd_updown = 1; cmd_cntsel = 3'b010; cmd_valid = 1;
    @(negedge clk);
    cmd_steps = 2; cmd_updown = 0; cmd_cntsel = 3'b011;
    n_cmp++; if ({busy, cmd_ready, steps_left} !== {2'b10, 8'd1}) begin n_bad++; $display("FAIL bb_first got=%h exp=%h", {busy, cmd_ready, steps_left}, {2'b10, 8'd1}); end
    for (int i = 0; i < 8000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (cmd_ready) early++;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bb_first_done got=%b exp=1", got); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL bb_ready_while_busy cycles got=%0d exp=0", early); end
    n_cmp++; if ({cmd_ready, steps_left} !== {1'b0, 8'd0}) begin n_bad++; $display("FAIL bb_done_cycle got=%h exp=%h", {cmd_ready, steps_left}, {1'b0, 8'd0}); end
    @(negedge clk);
    n_cmp++; if ({cmd_ready, busy, steps_left} !== {2'b10, 8'd0}) begin n_bad++; $display("FAIL bb_accept_cycle got=%h exp=%h", {cmd_ready, busy, steps_left}, {2'b10, 8'd0}); end
    @(negedge clk);
    cmd_valid = 0;
    n_cmp++; if ({busy, phaseupdown, phasecounterselect, steps_left} !== {2'b10, 3'b011, 8'd2}) begin n_bad++; $display("FAIL bb_second_load got=%h exp=%h", {busy, phaseupdown, phasecounterselect, steps_left}, {2'b10, 3'b011, 8'd2}); end
    wait_done(got);
    n_cmp++; if ({got, err_timeout, steps_left} !== {1'b1, 1'b0, 8'd0}) begin n_bad++; $display("FAIL bb_second_done got=%h exp=%h", {got, err_timeout, steps_left}, {1'b1, 1'b0, 8'd0}); end
    n_cmp++; if (ready_bad !== 0) begin n_bad++; $display("FAIL bb_ready_busy_overlap got=%0d exp=0", ready_bad); end
  endtask
`ifdef PLL_PHASE_TRACK_EN
  task automatic test_track;
    logic signed [15:0] p0 = phase_pos;
    bit got;
    int ok = 0;
    for (int i = 0; i < 4; i++) begin send(1, 1, 3'b000); wait_done(got); ok += int'(got); end
    send(1, 0, 3'b000); wait_done(got); ok += int'(got);
    n_cmp++; if (phase_pos !== p0 + 16'sd3) begin n_bad++; $display("FAIL tr_all got=%0d exp=%0d", phase_pos, p0 + 16'sd3); end
    send(2, 1, 3'b011); wait_done(got); ok += int'(got);
    n_cmp++; if (phase_pos !== p0 + 16'sd3) begin n_bad++; $display("FAIL tr_other_sel got=%0d exp=%0d", phase_pos, p0 + 16'sd3); end
    n_cmp++; if (ok !== 6) begin n_bad++; $display("FAIL tr_cmds_done got=%0d exp=6", ok); end
  endtask
`endif
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_three_steps();
    test_zero_steps();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef PLL_PHASE_TRACK_EN
    test_track();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pll_phase_stepper.md
Name: pll_phase_stepper

Overview:
Executes dynamic phase-shift commands on the Cyclone III PLL reconfiguration port (scanclk, phasestep, phaseupdown, phasecounterselect, phasedone). It sits directly downstream of the phase-sweep decision logic, which issues "step counter X by N, up or down" over a valid/ready handshake. Each step follows the PLL timing rules, waits for phase_done and has a timeout. The block reports completion and errors, and frees the sweep logic from scanclk bit-banging.

Parameters:
SCAN_DIV, 16, clk cycles per scanclk half-period (>=2)
PHASESTEP_CYC, 2, scanclk rising edges phasestep is held high (>=2)
TIMEOUT_CYC, 100, scanclk rising edges to wait for phase_done before abort
STEP_W, 8, width of step count

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_steps  in  STEP_W  number of single phase steps (0 allowed)
cmd_updown  in  1  1 = up, 0 = down
cmd_cntsel  in  3  000 all, 001 M, 010 C0 ... 110 C4
phase_done  in  1  PLL phasedone (async to clk)
scanclk  out  1  PLL scanclk
phasestep  out  1  PLL phasestep
phaseupdown  out  1  PLL phaseupdown
phasecounterselect  out  3  PLL counter select
busy  out  1  command in progress
done  out  1  one-clk pulse at command end
err_timeout  out  1  one-clk pulse, coincident with done, on abort
steps_left  out  STEP_W  remaining steps

Behaviour:
- Reset values: scanclk=0, phasestep=0, phaseupdown=1, phasecounterselect=000, busy=0, done=0, err_timeout=0, steps_left=0, cmd_ready=1, state IDLE.
- Reset asserted mid-operation aborts at once to the reset values. No done pulse is issued.
- phase_done passes through a 2-flop synchroniser before any use.
- The scanclk divider runs only when busy. In IDLE, scanclk is held low and the divider is cleared.
  - rise strobe = clk cycle in which scanclk goes 0->1.
  - fall strobe = clk cycle in which scanclk goes 1->0.
- phasestep, phaseupdown and phasecounterselect change only on fall strobes or in IDLE. The PLL registers them on the scanclk rise.
- Handshake: the command is accepted when cmd_valid && cmd_ready. All fields are latched. cmd_ready drops the next clk.
- A command is never accepted while busy. There is no queue.
- States:
  - IDLE: on accept, load steps_left=cmd_steps and drive phaseupdown and phasecounterselect from the command.
    - If cmd_steps==0: done pulses the clk after accept and the block stays in IDLE with no scanclk activity.
    - Otherwise go to SETUP, busy=1.
  - SETUP: wait one full scanclk period (one rise strobe). On the next fall strobe, set phasestep=1 and go to STEP.
  - STEP: count rise strobes. After PHASESTEP_CYC rises, deassert phasestep on the following fall strobe and go to WAITLOW.
  - WAITLOW: wait for synchronised phase_done==0, sampled at rise strobes. When seen, go to WAITHIGH.
  - WAITHIGH: wait for synchronised phase_done==1, sampled at rise strobes.
    - When seen, decrement steps_left.
    - If steps_left becomes 0, go to FINISH. Otherwise return to SETUP.
  - Timeout counter:
    - Clears on entry to WAITLOW. Counts rise strobes across WAITLOW plus WAITHIGH.
    - At TIMEOUT_CYC, abort: steps_left keeps its remaining value and the block goes to FINISH with error flagged.
  - FINISH: wait for the next fall strobe (scanclk is then low). Pulse done, plus err_timeout if aborted. Set busy=0 and return to IDLE.
- phaseupdown and phasecounterselect hold their last command values in IDLE.
- Step counter arithmetic: no wrap; steps_left is never decremented below 0.

Optional Feature:
PLL_PHASE_TRACK_EN: adds output phase_pos, signed 16 bits, reset 0.
- +1 per completed up step; -1 per completed down step.
- Only for cmd_cntsel==000; other selects leave it unchanged.
- Saturates at +32767 and -32768.
- Without the macro: no port and no logic.

Decomposition:
- Package pll_phase_pkg:
  - counter-select constants CNT_ALL=3'b000, CNT_M=3'b001, CNT_C0..CNT_C4=3'b010..3'b110;
  - state encoding IDLE, SETUP, STEP, WAITLOW, WAITHIGH, FINISH.
- Sub-module pll_scanclk_gen: divider with enable, producing scanclk and the rise/fall strobes.

Test Plan:
- 3 steps, up, cntsel 010; PLL model drops phase_done 1 scanclk after phasestep falls and raises it 2 later:
  - exactly 3 phasestep pulses, each >=2 scanclk rises wide;
  - steps_left 3->2->1->0;
  - one done, no err_timeout.
- cmd_steps=0 -> done 1 clk after accept; scanclk and phasestep never toggle; busy stays 0.
- phase_done stuck at 1 with 5 steps -> err_timeout and done together, TIMEOUT_CYC=100 rises after first phasestep deassert; steps_left=5.
- Reset mid WAITHIGH -> all outputs return to reset values within the same clk, no done pulse; next command executes normally.
- cmd_valid held high across two commands -> second accepted only in the clk after the first done; cmd_ready=0 throughout busy.
- With PLL_PHASE_TRACK_EN defined:
  - 4 up then 1 down on cntsel 000 -> phase_pos=3;
  - 2 up on cntsel 011 -> phase_pos unchanged.
